// File: rtl/char_disp_pkg.sv
// Shared constants and types for the character display path.
package char_disp_pkg;

  localparam int unsigned CODE_W    = 3;
  localparam int unsigned NUM_SLOTS = 8;

  // Character codes; any code with the MSB set displays as blank.
  localparam logic [CODE_W-1:0] CH_H     = 3'b000;
  localparam logic [CODE_W-1:0] CH_E     = 3'b001;
  localparam logic [CODE_W-1:0] CH_L     = 3'b010;
  localparam logic [CODE_W-1:0] CH_O     = 3'b011;
  localparam logic [CODE_W-1:0] CH_BLANK = 3'b111;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    COMMIT
  } loader_state_t;

endpackage

// File: rtl/char_shadow_bank.sv
// Eight-entry shadow buffer: one indexed write port, all slots read in parallel.
// Slot i occupies slots_o[i*CODE_W +: CODE_W].
module char_shadow_bank
  import char_disp_pkg::*;
#(
  parameter logic [CODE_W-1:0] BLANK_CODE = CH_BLANK
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        we_i,
  input  logic [2:0]                  idx_i,
  input  logic [CODE_W-1:0]           data_i,
  output logic [NUM_SLOTS*CODE_W-1:0] slots_o
);

  logic [NUM_SLOTS-1:0][CODE_W-1:0] mem_q;

  // Shadow storage, cleared to blank on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= {NUM_SLOTS{BLANK_CODE}};
    end else if (we_i) begin
      mem_q[idx_i] <= data_i;
    end
  end

  assign slots_o = mem_q;

endmodule

// File: rtl/char_frame_loader.sv
// Streams 3-bit character codes into a shadow buffer and commits whole frames
// atomically to eight registered display slots (u = slot 0 ... t = slot 7).
// Short frames are padded with BLANK_CODE.
// Optional feature macro: CHAR_SCROLL_EN adds a 'scroll' input that shifts the
// displayed slots left on each accept instead of filling the shadow buffer.
module char_frame_loader
  import char_disp_pkg::*;
#(
  parameter logic [CODE_W-1:0] BLANK_CODE = CH_BLANK
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
`ifdef CHAR_SCROLL_EN
  input  logic              scroll,
`endif
  output logic [CODE_W-1:0] u,
  output logic [CODE_W-1:0] v,
  output logic [CODE_W-1:0] w,
  output logic [CODE_W-1:0] x,
  output logic [CODE_W-1:0] y,
  output logic [CODE_W-1:0] z,
  output logic [CODE_W-1:0] p,
  output logic [CODE_W-1:0] t,
  output logic [2:0]        slot_ptr,
  output logic              frame_done
);

  localparam logic [2:0] LastSlot = 3'(NUM_SLOTS - 1);

  loader_state_t                    state_q;
  logic [2:0]                       slot_ptr_q;
  logic [NUM_SLOTS-1:0][CODE_W-1:0] disp_q;
  logic [NUM_SLOTS*CODE_W-1:0]      shadow_slots;
  logic                             scroll_mode;
  logic                             shadow_we;
  logic [CODE_W-1:0]                shadow_wdata;

`ifdef CHAR_SCROLL_EN
  assign scroll_mode = scroll;
`else
  assign scroll_mode = 1'b0;
`endif

  // Handshake and pulse decoded from state only; in_ready held low while in reset.
  assign in_ready   = (state_q == FILL) && !Reset;
  assign frame_done = (state_q == COMMIT);
  assign slot_ptr   = slot_ptr_q;

  // Shadow write: accepted codes in FILL (non-scroll), blanks every PAD cycle.
  always_comb begin
    shadow_we    = 1'b0;
    shadow_wdata = in_code;
    if (state_q == FILL) begin
      shadow_we = in_valid && !scroll_mode;
    end else if (state_q == PAD) begin
      shadow_we    = 1'b1;
      shadow_wdata = BLANK_CODE;
    end
  end

  char_shadow_bank #(
    .BLANK_CODE (BLANK_CODE)
  ) u_shadow (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (shadow_we),
    .idx_i   (slot_ptr_q),
    .data_i  (shadow_wdata),
    .slots_o (shadow_slots)
  );

  // Frame FSM with slot pointer and registered display outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= FILL;
      slot_ptr_q <= 3'd0;
      disp_q     <= {NUM_SLOTS{BLANK_CODE}};
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_valid) begin
            if (scroll_mode) begin
              disp_q <= {in_code, disp_q[NUM_SLOTS-1:1]};
            end else if (slot_ptr_q == LastSlot) begin
              // in_last on slot 7 is just a normal final code: no padding.
              state_q <= COMMIT;
            end else begin
              slot_ptr_q <= slot_ptr_q + 3'd1;
              if (in_last) state_q <= PAD;
            end
          end
        end
        PAD: begin
          // Pointer parks at 7; only COMMIT returns it to 0.
          if (slot_ptr_q == LastSlot) begin
            state_q <= COMMIT;
          end else begin
            slot_ptr_q <= slot_ptr_q + 3'd1;
          end
        end
        COMMIT: begin
          disp_q     <= shadow_slots;
          slot_ptr_q <= 3'd0;
          state_q    <= FILL;
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign u = disp_q[0];
  assign v = disp_q[1];
  assign w = disp_q[2];
  assign x = disp_q[3];
  assign y = disp_q[4];
  assign z = disp_q[5];
  assign p = disp_q[6];
  assign t = disp_q[7];

endmodule

// File: tb/tb_char_frame_loader.sv
// Directed bench for char_frame_loader. Display slots are compared as one
// 24-bit word {t,p,z,y,x,w,v,u} so slot 0 sits in the low bits.
module tb_char_frame_loader;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
`ifdef CHAR_SCROLL_EN
  logic       scroll;
`endif
  logic [2:0] u, v, w, x, y, z, p, t;
  logic [2:0] slot_ptr;
  logic       frame_done;

  int n_pass  = 0;
  int n_total = 0;

  char_frame_loader dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
`ifdef CHAR_SCROLL_EN
    .scroll     (scroll),
`endif
    .u          (u),
    .v          (v),
    .w          (w),
    .x          (x),
    .y          (y),
    .z          (z),
    .p          (p),
    .t          (t),
    .slot_ptr   (slot_ptr),
    .frame_done (frame_done)
  );

  always #5 Clock = ~Clock;

  function automatic logic [23:0] outs();
    return {t, p, z, y, x, w, v, u};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One-cycle transfer; in_ready is 1 in FILL so it is accepted at this edge.
  task automatic send(input logic [2:0] code, input logic last);
    in_code  = code;
    in_last  = last;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    in_code  = 3'b000;
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef CHAR_SCROLL_EN
    scroll   = 1'b0;
`endif
    #12;
    chk("rst_ready", 24'(in_ready), 24'd0);
    chk("rst_outs", outs(), 24'hFFFFFF);
    chk("rst_done", 24'(frame_done), 24'd0);
    Reset = 1'b0;
    #1;
    chk("idle_ready", 24'(in_ready), 24'd1);
    chk("idle_ptr", 24'(slot_ptr), 24'd0);
    step();
    chk("idle_outs", outs(), 24'hFFFFFF);

    // Full HELLO frame back-to-back.
    send(3'b000, 1'b0); send(3'b001, 1'b0); send(3'b010, 1'b0); send(3'b010, 1'b0);
    send(3'b011, 1'b0); send(3'b111, 1'b0); send(3'b111, 1'b0);
    chk("full_ptr7", 24'(slot_ptr), 24'd7);
    chk("full_ready7", 24'(in_ready), 24'd1);
    send(3'b111, 1'b0);
    chk("full_done", 24'(frame_done), 24'd1);
    chk("full_notready", 24'(in_ready), 24'd0);
    chk("full_outs_held", outs(), 24'hFFFFFF);
    step();
    chk("full_outs", outs(), {3'd7, 3'd7, 3'd7, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0});
    chk("full_done_low", 24'(frame_done), 24'd0);
    chk("full_ptr0", 24'(slot_ptr), 24'd0);

`ifdef CHAR_SCROLL_EN
    // Scroll O into the displayed HELLO frame.
    scroll = 1'b1;
    send(3'b011, 1'b1);
    scroll = 1'b0;
    chk("scroll_outs", outs(), {3'd3, 3'd7, 3'd7, 3'd7, 3'd3, 3'd2, 3'd2, 3'd1});
    chk("scroll_done", 24'(frame_done), 24'd0);
    chk("scroll_ptr", 24'(slot_ptr), 24'd0);
    chk("scroll_ready", 24'(in_ready), 24'd1);
`endif

    // Short frame H,E,L(last): 5 PAD cycles, source keeps valid high meanwhile.
    send(3'b000, 1'b0); send(3'b001, 1'b0); send(3'b010, 1'b1);
    chk("short_ptr3", 24'(slot_ptr), 24'd3);
    in_valid = 1'b1;
    in_code  = 3'b011;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pad_ready%0d", i), 24'(in_ready), 24'd0);
      chk($sformatf("pad_done%0d", i), 24'(frame_done), 24'd0);
      step();
    end
    in_valid = 1'b0;
    chk("short_done", 24'(frame_done), 24'd1);
    step();
    chk("short_outs", outs(), {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd2, 3'd1, 3'd0});
    chk("short_ptr0", 24'(slot_ptr), 24'd0);

    // in_valid toggling, 1xx codes stored verbatim.
    begin
      logic [2:0] codes [8] = '{3'd3, 3'd2, 3'd4, 3'd1, 3'd0, 3'd5, 3'd2, 3'd3};
      for (int i = 0; i < 8; i++) begin
        send(codes[i], 1'b0);
        if (i == 3) chk("tog_ptr4", 24'(slot_ptr), 24'd4);
        if (i < 7) begin
          in_code = 3'b110;
          step();
          chk($sformatf("tog_nodone%0d", i), 24'(frame_done), 24'd0);
        end
      end
    end
    chk("tog_done", 24'(frame_done), 24'd1);
    step();
    chk("tog_outs", outs(), {3'd3, 3'd2, 3'd5, 3'd0, 3'd1, 3'd4, 3'd2, 3'd3});

    // Asynchronous reset after 4 accepts discards the partial frame.
    send(3'b000, 1'b0); send(3'b001, 1'b0); send(3'b010, 1'b0); send(3'b011, 1'b0);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_ptr", 24'(slot_ptr), 24'd0);
    chk("mid_rst_outs", outs(), 24'hFFFFFF);
    chk("mid_rst_ready", 24'(in_ready), 24'd0);
    step();
    Reset = 1'b0;
    #1;
    // Clean frame, in_last on the 8th code: commit with no padding.
    send(3'b001, 1'b0); send(3'b001, 1'b0); send(3'b000, 1'b0); send(3'b011, 1'b0);
    send(3'b010, 1'b0); send(3'b000, 1'b0); send(3'b001, 1'b0);
    chk("post_rst_outs", outs(), 24'hFFFFFF);
    send(3'b011, 1'b1);
    chk("last7_done", 24'(frame_done), 24'd1);
    step();
    chk("clean_outs", outs(), {3'd3, 3'd1, 3'd0, 3'd2, 3'd3, 3'd0, 3'd1, 3'd1});

    // Reset during COMMIT loses the commit.
    for (int i = 0; i < 8; i++) send(3'b010, 1'b0);
    chk("cmt_done", 24'(frame_done), 24'd1);
    #2 Reset = 1'b1;
    #1;
    chk("cmt_rst_outs", outs(), 24'hFFFFFF);
    chk("cmt_rst_done", 24'(frame_done), 24'd0);
    step();
    Reset = 1'b0;
    step();
    chk("cmt_after_outs", outs(), 24'hFFFFFF);
    chk("cmt_after_ready", 24'(in_ready), 24'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
